// File: rtl/llc_pipe_arbiter_if.sv
// Handshake bundle between the four request sources, the update stage and
// the set-read stage of the LLC pipeline arbiter.
// slave  : the arbiter's view of the bundle.
// master : the environment's view (sources, update stage, set-read stage).
interface llc_pipe_arbiter_if #(
  parameter int CNT_W = 2
);
  logic             rsp_valid_i;
  logic             rsp_ready_o;
  logic             rst_tb_valid_i;
  logic             rst_tb_ready_o;
  logic             req_valid_i;
  logic             req_ready_o;
  logic             dma_valid_i;
  logic             dma_ready_o;
  logic             req_stall_i;
  logic             dma_stall_i;
  logic             done_i;
  logic             sel_valid_o;
  logic             sel_ready_i;
  logic [1:0]       sel_src_o;
  logic [CNT_W-1:0] inflight_o;
  logic             idle_o;

  modport slave (
    input  rsp_valid_i, rst_tb_valid_i, req_valid_i, dma_valid_i,
    input  req_stall_i, dma_stall_i, done_i, sel_ready_i,
    output rsp_ready_o, rst_tb_ready_o, req_ready_o, dma_ready_o,
    output sel_valid_o, sel_src_o, inflight_o, idle_o
  );

  modport master (
    output rsp_valid_i, rst_tb_valid_i, req_valid_i, dma_valid_i,
    output req_stall_i, dma_stall_i, done_i, sel_ready_i,
    input  rsp_ready_o, rst_tb_ready_o, req_ready_o, dma_ready_o,
    input  sel_valid_o, sel_src_o, inflight_o, idle_o
  );
endinterface

// File: rtl/llc_pipe_arbiter.sv
// LLC pipeline front-end arbiter.
// Picks one of four sources (rsp > rst_tb > req > dma) per cycle, holds the
// grant in a one-entry output register toward the set-read stage and limits
// the number of transactions granted but not yet retired by the update stage.
// Optional feature: define LLC_ARB_STARVE_GUARD_EN to let a starved dma source
// outrank req for one grant after STARVE_LIMIT consecutive req grants.
module llc_pipe_arbiter #(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  llc_pipe_arbiter_if.slave  bus
);

  localparam logic [0:0]       ST_EMPTY  = 1'b0;
  localparam logic [0:0]       ST_LOADED = 1'b1;
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_INFLIGHT);

  logic [0:0]       state_q, state_d;
  logic [1:0]       sel_src_q, sel_src_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;

  logic [3:0]       eligible;
  logic             can_grant;
  logic             grant;
  logic [1:0]       winner;
  logic [3:0]       ready_vec;
  logic             dma_first;
  logic             retire;

  // Sources that may win this cycle; a stalled source is invisible to arbitration.
  assign eligible = {bus.dma_valid_i & ~bus.dma_stall_i,
                     bus.req_valid_i & ~bus.req_stall_i,
                     bus.rst_tb_valid_i,
                     bus.rsp_valid_i};

  // Output slot free (or draining this cycle) and room left for one more transaction.
  // The registered count is used on purpose: a retire this cycle does not open a slot yet.
  assign can_grant = ((state_q == ST_EMPTY) || bus.sel_ready_i) && (inflight_q < MAX_CNT);

  // Fixed-priority pick, with dma optionally promoted above req.
  always_comb begin
    winner = 2'd0;
    if (eligible[0])
      winner = 2'd0;
    else if (eligible[1])
      winner = 2'd1;
    else if (dma_first && eligible[3])
      winner = 2'd3;
    else if (eligible[2])
      winner = 2'd2;
    else if (eligible[3])
      winner = 2'd3;
  end

  assign grant     = can_grant && (|eligible) && !rst;
  assign ready_vec = grant ? (4'b0001 << winner) : 4'b0000;
  assign retire    = bus.done_i && (inflight_q != '0);

  // Next-state for the output slot, the held source and the in-flight count.
  always_comb begin
    state_d    = state_q;
    sel_src_d  = sel_src_q;
    inflight_d = inflight_q;
    if (grant) begin
      state_d   = ST_LOADED;
      sel_src_d = winner;
    end else if ((state_q == ST_LOADED) && bus.sel_ready_i) begin
      state_d = ST_EMPTY;
    end
    case ({grant, retire})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  // Pipeline registers; reset drops any held grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      sel_src_q  <= 2'd0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_src_q  <= sel_src_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef LLC_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          dma_pending;

  assign dma_pending = bus.dma_valid_i & ~bus.dma_stall_i;
  assign dma_first   = (starve_q >= SW'(STARVE_LIMIT));

  // Count req grants that overtook a pending dma; any dma grant or dma going away clears it.
  always_comb begin
    starve_d = starve_q;
    if (!dma_pending)
      starve_d = '0;
    else if (grant && (winner == 2'd3))
      starve_d = '0;
    else if (grant && (winner == 2'd2) && !dma_first)
      starve_d = starve_q + 1'b1;
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve_q <= '0;
    else
      starve_q <= starve_d;
  end
`else
  // Strict priority: dma never outranks req.
  assign dma_first = (STARVE_LIMIT < 0);
`endif

  assign bus.rsp_ready_o    = ready_vec[0];
  assign bus.rst_tb_ready_o = ready_vec[1];
  assign bus.req_ready_o    = ready_vec[2];
  assign bus.dma_ready_o    = ready_vec[3];
  assign bus.sel_valid_o    = (state_q == ST_LOADED);
  assign bus.sel_src_o      = sel_src_q;
  assign bus.inflight_o     = inflight_q;
  assign bus.idle_o         = rst ||
                              ((state_q == ST_EMPTY) && (inflight_q == '0) &&
                               !(bus.rsp_valid_i || bus.rst_tb_valid_i ||
                                 bus.req_valid_i || bus.dma_valid_i));

endmodule

// File: tb/tb_llc_pipe_arbiter.sv
// Self-checking bench for llc_pipe_arbiter: table vectors, hand sequences for
// the multi-cycle corners and a randomized run against a behavioural model.
// Build with LLC_ARB_STARVE_GUARD_EN defined to check the starvation guard.
module tb_llc_pipe_arbiter;

  localparam int MAX   = 3;
  localparam int LIMIT = 4;
`ifdef LLC_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  llc_pipe_arbiter_if #(.CNT_W(2)) bus ();

  llc_pipe_arbiter #(
    .MAX_INFLIGHT (MAX),
    .CNT_W        (2),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Behavioural model: is a grant held, which source, how many unretired, starvation run.
  bit m_loaded;
  int m_src;
  int m_inflight;
  int m_starve;

  logic [3:0] obs_ready;
  logic       obs_idle;

  typedef struct {
    logic [3:0] v;          // {dma, req, rst_tb, rsp}
    bit         rs;
    bit         ds;
    logic [3:0] exp_ready;
    int         exp_src;
    bit         exp_valid;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [3:0] dut_ready();
    return {bus.dma_ready_o, bus.req_ready_o, bus.rst_tb_ready_o, bus.rsp_ready_o};
  endfunction

  task automatic drive(input logic [3:0] v, input bit rs, input bit ds,
                       input bit sr, input bit dn);
    bus.rsp_valid_i    = v[0];
    bus.rst_tb_valid_i = v[1];
    bus.req_valid_i    = v[2];
    bus.dma_valid_i    = v[3];
    bus.req_stall_i    = rs;
    bus.dma_stall_i    = ds;
    bus.sel_ready_i    = sr;
    bus.done_i         = dn;
  endtask

  // Which source wins under the stated rules, or -1 when nothing is granted.
  function automatic int model_winner(input logic [3:0] v, input bit rs, input bit ds,
                                      input bit sr);
    int order[4];
    bit elig[4];
    elig[0] = v[0];
    elig[1] = v[1];
    elig[2] = v[2] && !rs;
    elig[3] = v[3] && !ds;
    order = '{0, 1, 2, 3};
    if (GUARD && m_starve >= LIMIT) order = '{0, 1, 3, 2};
    if ((m_loaded && !sr) || m_inflight >= MAX) return -1;
    foreach (order[k]) if (elig[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic model_reset();
    m_loaded   = 1'b0;
    m_src      = 0;
    m_inflight = 0;
    m_starve   = 0;
  endtask

  // One clock: drive at negedge, check handshake outputs, clock, check registered outputs.
  task automatic step(input logic [3:0] v, input bit rs, input bit ds,
                      input bit sr, input bit dn, input string tag);
    int         w;
    logic [3:0] exp_r;
    bit         exp_idle;
    @(negedge clk);
    drive(v, rs, ds, sr, dn);
    #1;
    w        = model_winner(v, rs, ds, sr);
    exp_r    = (w >= 0) ? 4'(1 << w) : 4'b0000;
    exp_idle = !m_loaded && (m_inflight == 0) && (v == 4'b0000);
    obs_ready = dut_ready();
    obs_idle  = bus.idle_o;
    chk({tag, " ready"}, int'(obs_ready), int'(exp_r));
    chk({tag, " idle"},  int'(obs_idle),  int'(exp_idle));
    @(posedge clk);
    #1;
    if (!(v[3] && !ds))     m_starve = 0;
    else if (w == 3)        m_starve = 0;
    else if (w == 2 && m_starve < LIMIT) m_starve++;
    if (w >= 0) begin
      m_loaded = 1'b1;
      m_src    = w;
    end else if (sr) begin
      m_loaded = 1'b0;
    end
    m_inflight = m_inflight + ((w >= 0) ? 1 : 0) - ((dn && m_inflight > 0) ? 1 : 0);
    if (w >= 0) $display("grant %s: src=%0d inflight=%0d", tag, w, m_inflight);
    chk({tag, " sel_valid"}, int'(bus.sel_valid_o), int'(m_loaded));
    chk({tag, " sel_src"},   int'(bus.sel_src_o),   m_src);
    chk({tag, " inflight"},  int'(bus.inflight_o),  m_inflight);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst sel_valid", int'(bus.sel_valid_o), 0);
    chk("rst sel_src",   int'(bus.sel_src_o),   0);
    chk("rst inflight",  int'(bus.inflight_o),  0);
    chk("rst idle",      int'(bus.idle_o),      1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #12;
    chk("por ready", int'(dut_ready()), 0);
    do_reset();

    // Single-cycle grant vectors from an empty arbiter.
    vecs[0] = '{4'b1111, 1'b0, 1'b0, 4'b0001, 0, 1'b1};
    vecs[1] = '{4'b1110, 1'b0, 1'b0, 4'b0010, 1, 1'b1};
    vecs[2] = '{4'b1100, 1'b0, 1'b0, 4'b0100, 2, 1'b1};
    vecs[3] = '{4'b1000, 1'b0, 1'b0, 4'b1000, 3, 1'b1};
    vecs[4] = '{4'b1100, 1'b1, 1'b0, 4'b1000, 3, 1'b1};
    vecs[5] = '{4'b1100, 1'b1, 1'b1, 4'b0000, 0, 1'b0};
    vecs[6] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1'b0};
    vecs[7] = '{4'b1010, 1'b0, 1'b0, 4'b0010, 1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      step(vecs[i].v, vecs[i].rs, vecs[i].ds, 1'b1, 1'b0, "vec");
      chk("vec exp_ready", int'(obs_ready),       int'(vecs[i].exp_ready));
      chk("vec exp_src",   int'(bus.sel_src_o),   vecs[i].exp_src);
      chk("vec exp_valid", int'(bus.sel_valid_o), int'(vecs[i].exp_valid));
    end

    // Fill to MAX_INFLIGHT, then a retire opens a slot only on the following cycle.
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, "full");
    chk("full inflight", int'(bus.inflight_o), 3);
    step(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, "full");
    chk("full blocked", int'(obs_ready), 0);
    step(4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, "full");
    chk("full done cycle ready", int'(obs_ready), 0);
    chk("full done inflight", int'(bus.inflight_o), 2);
    step(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, "full");
    chk("full regrant ready", int'(obs_ready), 4'b0100);
    chk("full regrant inflight", int'(bus.inflight_o), 3);

    // Backpressure: held grant stays put, then drains with a new grant the same cycle.
    do_reset();
    step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, "hold");
    chk("hold first src", int'(bus.sel_src_o), 2);
    for (int i = 0; i < 4; i++) begin
      step(4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, "hold");
      chk("hold no ready", int'(obs_ready), 0);
      chk("hold src", int'(bus.sel_src_o), 2);
    end
    step(4'b1001, 1'b0, 1'b0, 1'b1, 1'b0, "hold");
    chk("drain ready", int'(obs_ready), 4'b0001);
    chk("drain src", int'(bus.sel_src_o), 0);
    chk("drain valid", int'(bus.sel_valid_o), 1);

    // Continuous req and dma traffic.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(4'b1100, 1'b0, 1'b0, 1'b1, 1'b1, "stream");
      chk("stream src", int'(bus.sel_src_o), (GUARD && i == 4) ? 3 : 2);
      chk("stream inflight", int'(bus.inflight_o), 1);
    end

    // Reset while loaded with two in flight.
    do_reset();
    step(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, "pre_rst");
    step(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, "pre_rst");
    chk("pre_rst inflight", int'(bus.inflight_o), 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst sel_valid", int'(bus.sel_valid_o), 0);
    chk("mid_rst inflight",  int'(bus.inflight_o),  0);
    chk("mid_rst ready",     int'(dut_ready()),     0);
    chk("mid_rst idle",      int'(bus.idle_o),      1);
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, "post_rst");
    chk("post_rst idle", int'(obs_idle), 1);
    step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, "post_rst");
    chk("post_rst idle2", int'(obs_idle), 1);
    step(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, "post_rst");
    chk("post_rst busy", int'(obs_idle), 0);
    chk("post_rst grant", int'(obs_ready), 4'b0100);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] v;
      if ($urandom_range(0, 99) == 0) do_reset();
      v = 4'($urandom);
      step(v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4), "rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
